// File: rtl/bcd_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_serial_add_ctrl
//
// Multi-digit packed-BCD add/subtract controller. A single one-digit BCD
// adder stage (binary add, then +6 decimal adjust with carry) is reused for
// every digit, one digit per clock, least significant digit first.
// Subtraction adds the 9's complement of b with an initial carry of 1, which
// gives the 10's-complement difference.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst    asynchronous active-high reset
//   i_start  operation request, only looked at while idle
//   i_sub    0: a+b, 1: a-b (captured with i_start)
//   i_a      packed BCD operand, digit i at [4i+3:4i]
//   i_b      packed BCD operand, same packing
//   o_busy   high while digits are being processed
//   o_done   one-cycle pulse when o_sum/o_cout/o_err are final
//   o_sum    packed BCD result, holds until the next accepted start
//   o_cout   final decimal carry (add) / no-borrow flag (sub)
//   o_err    a captured operand contained a digit greater than 9
// ---------------------------------------------------------------------------
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_sub,
  input  logic [4*DIGITS-1:0]   i_a,
  input  logic [4*DIGITS-1:0]   i_b,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_sum,
  output logic                  o_cout,
  output logic                  o_err
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_nextState;

  logic [4*DIGITS-1:0] r_opA;
  logic [4*DIGITS-1:0] r_opB;
  logic                r_sub;
  logic [CW-1:0]       r_cnt;
  logic                r_carry;
  logic [4*DIGITS-1:0] r_sum;
  logic                r_cout;
  logic                r_err;
  logic                r_done;

  logic                w_aBad;
  logic                w_bBad;
  logic [3:0]          w_aDigit;
  logic [3:0]          w_bRaw;
  logic [3:0]          w_bDigit;
  logic [4:0]          w_binSum;
  logic [4:0]          w_adjSum;
  logic [3:0]          w_digit;
  logic                w_carryOut;
  logic                w_last;

  // Flag any non-decimal nibble on the incoming operands so the error can be
  // registered in the same edge that captures them.
  always_comb begin
    w_aBad = 1'b0;
    w_bBad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i_a[4*i +: 4] > 4'd9) w_aBad = 1'b1;
      if (i_b[4*i +: 4] > 4'd9) w_bBad = 1'b1;
    end
  end

  // The shared single-digit BCD adder. For subtraction b is replaced by its
  // 9's complement; the carry seeded with 1 at start completes the 10's
  // complement. Illegal digits simply wrap here since the result is then
  // don't-care anyway.
  always_comb begin
    w_aDigit   = r_opA[r_cnt*4 +: 4];
    w_bRaw     = r_opB[r_cnt*4 +: 4];
    w_bDigit   = r_sub ? (4'd9 - w_bRaw) : w_bRaw;
    w_binSum   = {1'b0, w_aDigit} + {1'b0, w_bDigit} + {4'b0000, r_carry};
    w_adjSum   = w_binSum + 5'd6;
    w_carryOut = (w_binSum > 5'd9);
    w_digit    = w_carryOut ? w_adjSum[3:0] : w_binSum[3:0];
    w_last     = (r_cnt == CW'(DIGITS - 1));
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: start is only honoured from IDLE, so requests made
  // while running are dropped rather than queued.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_start) w_nextState = RUN;
      RUN:     if (w_last)  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath registers. Capturing on start clears the previous result; each
  // RUN cycle writes one digit and advances the ripple carry. The final
  // digit also latches cout and raises done for exactly that one cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_opA   <= '0;
      r_opB   <= '0;
      r_sub   <= 1'b0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_opA   <= i_a;
            r_opB   <= i_b;
            r_sub   <= i_sub;
            r_cnt   <= '0;
            r_carry <= i_sub;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_err   <= w_aBad | w_bBad;
          end
        end
        RUN: begin
          r_sum[r_cnt*4 +: 4] <= w_digit;
          r_carry             <= w_carryOut;
          if (w_last) begin
            r_cnt  <= '0;
            r_cout <= w_carryOut;
            r_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state == RUN);
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_err  = r_err;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_serial_add_ctrl
//
// Self-checking bench for bcd_serial_add_ctrl with four digits. Directed
// vectors from a table, randomized operations checked against a decimal
// arithmetic reference model, plus hand-written back-to-back and
// reset-during-run sequences.
// ---------------------------------------------------------------------------
module tb_bcd_serial_add_ctrl;

  localparam int D = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          sub;
  logic [4*D-1:0] a;
  logic [4*D-1:0] b;
  logic          busy;
  logic          done;
  logic [4*D-1:0] sum;
  logic          cout;
  logic          err;

  int nChecks;
  int nPass;

  typedef struct {
    logic          sub;
    logic [4*D-1:0] a;
    logic [4*D-1:0] b;
    logic [4*D-1:0] expSum;
    logic          expCout;
    logic          expErr;
  } vec_t;

  vec_t vecs[7];

  bcd_serial_add_ctrl #(.DIGITS(D)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_sub   (sub),
    .i_a     (a),
    .i_b     (b),
    .o_busy  (busy),
    .o_done  (done),
    .o_sum   (sum),
    .o_cout  (cout),
    .o_err   (err)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and keep the tallies.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Decimal reference: decode both operands to integers, do the arithmetic
  // the way a person would, then re-encode the result as BCD.
  function automatic void refModel(input logic s, input logic [4*D-1:0] va, input logic [4*D-1:0] vb,
                                   output logic [4*D-1:0] rs, output logic rc, output logic re);
    int av, bv, r, pw;
    av = 0; bv = 0; re = 1'b0; pw = 1;
    for (int i = D - 1; i >= 0; i--) begin
      if (va[4*i +: 4] > 4'd9) re = 1'b1;
      if (vb[4*i +: 4] > 4'd9) re = 1'b1;
      av = av * 10 + int'(va[4*i +: 4]);
      bv = bv * 10 + int'(vb[4*i +: 4]);
      pw = pw * 10;
    end
    if (!s) begin
      r  = av + bv;
      rc = (r >= pw);
      r  = r % pw;
    end else if (av >= bv) begin
      r  = av - bv;
      rc = 1'b1;
    end else begin
      r  = pw - (bv - av);
      rc = 1'b0;
    end
    rs = '0;
    for (int i = 0; i < D; i++) begin
      rs[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endfunction

  // Issue one operation, then check busy/err right after acceptance, the
  // start-to-done latency, the final results and that done is one cycle wide.
  task automatic applyStimulus(input string tag, input logic s, input logic [4*D-1:0] va,
                               input logic [4*D-1:0] vb, input logic [4*D-1:0] expSum,
                               input logic expCout, input logic expErr);
    int lat;
    @(negedge clk);
    start = 1'b1; sub = s; a = va; b = vb;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, " busy_after_start"}, 32'(busy), 32'd1);
    checkOutput({tag, " err_early"}, 32'(err), 32'(expErr));
    lat = 0;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(D));
    checkOutput({tag, " busy_at_done"}, 32'(busy), 32'd0);
    checkOutput({tag, " err"}, 32'(err), 32'(expErr));
    if (!expErr) begin
      checkOutput({tag, " sum"}, 32'(sum), 32'(expSum));
      checkOutput({tag, " cout"}, 32'(cout), 32'(expCout));
    end
    @(negedge clk);
    checkOutput({tag, " done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [4*D-1:0] ra, rb, rs;
    logic           rsub, rc, re;

    nChecks = 0;
    nPass   = 0;
    start   = 1'b0;
    sub     = 1'b0;
    a       = '0;
    b       = '0;

    vecs[0] = '{1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 16'h1234, 16'h5000, 16'h6234, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 16'h4321, 16'h4321, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1};

    // Power-on reset and reset values.
    rst = 1'b1;
    #12;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset sum",  32'(sum),  32'd0);
    checkOutput("reset cout", 32'(cout), 32'd0);
    checkOutput("reset err",  32'(err),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].sub, vecs[i].a, vecs[i].b,
                    vecs[i].expSum, vecs[i].expCout, vecs[i].expErr);
    end

    // Randomized legal operands against the decimal model.
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < D; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      rsub = 1'($urandom_range(0, 1));
      refModel(rsub, ra, rb, rs, rc, re);
      applyStimulus($sformatf("rand%0d", n), rsub, ra, rb, rs, rc, re);
    end

    // Start held high: a new operation every D+1 cycles, done once each.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 16'h0001; b = 16'h0001;
    for (int k = 1; k <= 3 * (D + 1); k++) begin
      @(negedge clk);
      checkOutput($sformatf("b2b done k=%0d", k), 32'(done), 32'((k % (D + 1)) == 0));
      checkOutput($sformatf("b2b busy k=%0d", k), 32'(busy), 32'((k % (D + 1)) != 0));
      if ((k % (D + 1)) == 0) begin
        checkOutput($sformatf("b2b sum k=%0d", k), 32'(sum), 32'h0002);
      end
      if (k == 3 * (D + 1)) start = 1'b0;
    end
    @(negedge clk);
    checkOutput("b2b idle after", 32'(busy), 32'd0);

    // Reset two cycles into a run aborts it with no done pulse.
    start = 1'b1; sub = 1'b0; a = 16'h1234; b = 16'h5678;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort sum",  32'(sum),  32'd0);
    checkOutput("abort cout", 32'(cout), 32'd0);
    checkOutput("abort err",  32'(err),  32'd0);
    for (int k = 0; k < D + 2; k++) begin
      @(negedge clk);
      checkOutput($sformatf("abort no done %0d", k), 32'(done), 32'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < D + 2; k++) begin
      @(negedge clk);
      checkOutput($sformatf("post abort no done %0d", k), 32'(done), 32'd0);
    end
    applyStimulus("after reset", 1'b0, 16'h0009, 16'h0009, 16'h0018, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/bcd_serial_add_ctrl.md
# bcd_serial_add_ctrl

Sequential controller for multi-digit packed-BCD add/subtract. It time-shares one single-digit BCD adder stage (decimal-adjust +6 correction, carry-in/carry-out) across all digits, processing one digit per clock, least significant digit first. It sits between a requester issuing start/operand pulses and downstream logic consuming a registered BCD result. Subtraction uses the 9's-complement method.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1); internal digit counter width = max(1, clog2(DIGITS))
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- sub  input  1  0: sum=a+b; 1: sum=a−b (10's-complement result); captured with start
- a  input  4*DIGITS  packed BCD operand; digit i at bits [4i+3:4i]; captured with start
- b  input  4*DIGITS  packed BCD operand; same packing; captured with start
- busy  output  1  high while digits are being processed
- done  output  1  single-cycle pulse when sum/cout/err are final
- sum  output  4*DIGITS  packed BCD result; registered; holds until the next accepted start
- cout  output  1  final decimal carry (add) / no-borrow flag (sub)
- err  output  1  a captured operand contained a digit >9

## Operation
- FSM states: IDLE, RUN.
- IDLE, start=1: capture a, b, sub into operand registers; digit counter←0; carry←sub; clear sum to 0 and cout to 0; err←1 if any digit of a or b >9, else 0; go to RUN.
- IDLE, start=0: hold all outputs.
- RUN, each cycle, for digit i = counter:
  - ad = a digit i; bd = sub ? (9−bd_raw) : bd_raw.
  - s = ad + bd + carry, computed 5 bits wide (max 19).
  - If s>9: digit = (s+6)[3:0], carry←1; else digit = s[3:0], carry←0.
  - Write the digit into sum[4i+3:4i]; increment the counter.
  - On i=DIGITS−1: cout←final carry, done←1, go to IDLE.
- start is ignored while RUN; there is no queueing.
- Subtract semantics: cout=1 means a≥b and sum=a−b. cout=0 means a<b and sum = 10^DIGITS − (b−a).
- When err=1, sum and cout are unspecified, but the sequence still completes with normal timing.

## Timing
- Reset (async assert): state=IDLE, busy=0, done=0, sum=0, cout=0, err=0, counter=0, carry=0. Release is synchronous to clk.
- Reset asserted during RUN aborts the operation immediately. No done pulse is produced, and outputs go to their reset values.
- Edge E0 samples start=1: busy=1 after E0. err is valid after E0.
- Digit i is written at edge E(i+1).
- At edge E(DIGITS): the last digit and cout are written, done=1, busy=0. All results are valid in that same cycle.
- Latency from start to done is DIGITS cycles. The next operation may be accepted at E(DIGITS)+1, i.e. start may be asserted during the done cycle (back-to-back throughput is DIGITS+1 cycles per operation).
- done is high for exactly one cycle per accepted start.
- DIGITS=1: busy is high for one cycle, and done follows at E1.

## Test plan
(DIGITS=4 unless stated)
- Add 1234+5678 with sub=0 -> done 4 cycles after start; sum=0x6912, cout=0, err=0.
- Add 9999+0001 -> sum=0x0000, cout=1; add 0000+0000 -> sum=0x0000, cout=0.
- Subtract 5000−1234 -> sum=0x3766, cout=1. Subtract 1234−5000 -> sum=0x6234, cout=0.
- a=0x12A4 -> err=1 the cycle after start; done still arrives 4 cycles after start.
- Hold start high continuously with 0001+0001 -> operations are accepted every 5 cycles; start during busy is ignored; exactly one done per accepted start; sum=0x0002.
- Assert rst 2 cycles into RUN -> busy=0, done never pulses, sum=0, cout=0, err=0. A fresh start after reset release (0009+0009) gives sum=0x0018, cout=0.
